prng_stream: RTL and testbench

PRNG_STREAM -- requirements
Module: prng_stream

---
 rtl/prng_pkg.sv | 15 +
 rtl/aes_sbox.sv | 48 ++++
 rtl/lfsr_core.sv | 49 ++++
 rtl/prng_stream.sv | 115 +++++++++++
 tb/tb_prng_stream.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/prng_pkg.sv
// Shared FSM state encoding and LFSR mode constants for the PRNG stream block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    VALID = 2'd2
  } prng_state_t;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] subst
);

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  // Inverse then affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    inv   = gf_inv(data);
    subst = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
  end

endmodule

// File: rtl/lfsr_core.sv
// LFSR holding the generator state; Fibonacci or Galois stepping, mode latched at load.
// Latency: bit_out is combinational from current state; state advances one step per step pulse.
// Backpressure: state holds whenever step and load are both low.
module lfsr_core
  import prng_pkg::*;
#(
  parameter int                LFSR_W   = 8,
  parameter logic [LFSR_W-1:0] FIB_TAPS = 8'hB8,
  parameter logic [LFSR_W-1:0] GAL_POLY = 8'h71
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  input  logic              mode,
  output logic              bit_out
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] next_state;
  logic              mode_q;
  logic              fib_fb;

  // Output bit and successor state for the latched mode.
  always_comb begin
    fib_fb     = ^(state_q & FIB_TAPS);
    bit_out    = fib_fb;
    next_state = {state_q[LFSR_W-2:0], fib_fb};
    if (mode_q == MODE_GAL) begin
      bit_out    = state_q[LFSR_W-1];
      next_state = (state_q << 1) ^ (state_q[LFSR_W-1] ? GAL_POLY : '0);
    end
  end

  // State register; an all-zero seed would lock up the LFSR, so it is replaced by 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= '0;
      mode_q  <= MODE_FIB;
    end else if (load) begin
      state_q <= (seed == '0) ? LFSR_W'(1) : seed;
      mode_q  <= mode;
    end else if (step) begin
      state_q <= next_state;
    end
  end

endmodule

// File: rtl/prng_stream.sv
// Streams OUT_W-bit pseudo-random words from a seeded LFSR, optionally S-box whitened.
// Latency: out_valid rises OUT_W+1 edges after the start-sampling edge (counting that edge).
// Backpressure: word and LFSR hold in VALID until out_ready; cont=1 at handshake continues.
module prng_stream
  import prng_pkg::*;
#(
  parameter int                LFSR_W   = 8,
  parameter logic [LFSR_W-1:0] FIB_TAPS = 8'hB8,
  parameter logic [LFSR_W-1:0] GAL_POLY = 8'h71,
  parameter int                OUT_W    = 8,
  parameter int                WHITEN   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              cont,
  input  logic [LFSR_W-1:0] seed,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W - 1);

  prng_state_t      state_q;
  prng_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] out_q;
  logic             load;
  logic             step;
  logic             bit_out;
  logic             restart;

  lfsr_core #(
    .LFSR_W  (LFSR_W),
    .FIB_TAPS(FIB_TAPS),
    .GAL_POLY(GAL_POLY)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .seed   (seed),
    .step   (step),
    .mode   (mode),
    .bit_out(bit_out)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and control strobes; start only matters in IDLE, mode only at load.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == LAST_CNT) state_d = VALID;
      end
      VALID: begin
        if (out_ready) begin
          restart = cont;
          state_d = cont ? SHIFT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output shift register (first bit ends at MSB) and shift counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      if (load || restart) cnt_q <= '0;
      if (step) begin
        out_q <= (out_q << 1) | OUT_W'(bit_out);
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = (state_q == VALID);
  assign busy      = (state_q != IDLE);

  // Whitening needs OUT_W to be a whole number of bytes.
  generate
    if (WHITEN != 0) begin : g_whiten
      for (genvar b = 0; b < OUT_W / 8; b++) begin : g_byte
        aes_sbox u_sbox (
          .data (out_q[8*b +: 8]),
          .subst(out_data[8*b +: 8])
        );
      end
    end else begin : g_raw
      assign out_data = out_q;
    end
  endgenerate

endmodule

// File: tb/tb_prng_stream.sv
// Directed bench: raw and whitened instances share stimulus; scoreboard queues hold words.
// Latency: expected words are popped by a monitor at each valid/ready handshake.
// Backpressure: out_ready is held low for a stretch to check the word holds.
module tb_prng_stream;
  import prng_pkg::*;

  logic       clock;
  logic       reset;
  logic       start;
  logic       mode;
  logic       cont;
  logic [7:0] seed;
  logic       out_ready;
  logic       out_valid_raw, out_valid_wht;
  logic [7:0] out_data_raw, out_data_wht;
  logic       busy_raw, busy_wht;

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  logic [7:0] exp_raw_q[$];
  logic [7:0] exp_wht_q[$];

  prng_stream #(.WHITEN(0)) u_raw (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .cont(cont),
    .seed(seed), .out_ready(out_ready), .out_valid(out_valid_raw),
    .out_data(out_data_raw), .busy(busy_raw)
  );

  prng_stream #(.WHITEN(1)) u_wht (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .cont(cont),
    .seed(seed), .out_ready(out_ready), .out_valid(out_valid_wht),
    .out_data(out_data_wht), .busy(busy_wht)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] raw, input logic [7:0] wht);
    exp_raw_q.push_back(raw);
    exp_wht_q.push_back(wht);
  endtask

  // Present start for exactly one sampling edge.
  task automatic start_word(input logic [7:0] s, input logic m, input logic c);
    seed  = s;
    mode  = m;
    cont  = c;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // n counts edges from the most recent state-changing edge (which is edge 1).
  task automatic wait_valid(output int cnt);
    cnt = 1;
    while (!out_valid_raw && cnt < 40) begin
      @(posedge clock); #1;
      cnt++;
    end
  endtask

  // Monitor: every handshake on either instance consumes one expected word.
  always @(negedge clock) begin
    if (!reset && out_valid_raw && out_ready) begin
      if (exp_raw_q.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL raw_word: got %0h, required no word", out_data_raw);
      end else begin
        check("raw_word", {24'h0, out_data_raw}, {24'h0, exp_raw_q.pop_front()});
      end
    end
    if (!reset && out_valid_wht && out_ready) begin
      if (exp_wht_q.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL wht_word: got %0h, required no word", out_data_wht);
      end else begin
        check("wht_word", {24'h0, out_data_wht}, {24'h0, exp_wht_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, required end of test");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = MODE_FIB; cont = 1'b0; seed = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clock); #1;
    check("rst_valid", out_valid_raw, 0);
    check("rst_busy", busy_raw, 0);
    check("rst_data_raw", out_data_raw, 8'h00);
    check("rst_data_wht", out_data_wht, 8'h63);
    reset = 1'b0;
    out_ready = 1'b1;

    // Fibonacci, seed 0x01
    push(8'h1C, 8'h9C);
    start_word(8'h01, MODE_FIB, 1'b0);
    wait_valid(n);
    check("fib_latency", n, 9);
    @(posedge clock); #1;
    check("fib_drop_valid", out_valid_raw, 0);
    check("fib_drop_busy", busy_raw, 0);

    // Galois, seed 0x80
    push(8'hB1, 8'hC8);
    start_word(8'h80, MODE_GAL, 1'b0);
    check("gal_busy", busy_raw, 1);
    wait_valid(n);
    check("gal_latency", n, 9);
    @(posedge clock); #1;
    check("gal_drop_valid", out_valid_raw, 0);

    // Zero seed is substituted by 1
    push(8'h1C, 8'h9C);
    start_word(8'h00, MODE_FIB, 1'b0);
    wait_valid(n);
    check("zero_latency", n, 9);
    @(posedge clock); #1;

    // Continuation with backpressure
    out_ready = 1'b0;
    push(8'h1C, 8'h9C);
    push(8'h4B, 8'hB3);
    start_word(8'h01, MODE_FIB, 1'b1);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("hold_valid", out_valid_raw, 1);
      check("hold_raw", out_data_raw, 8'h1C);
      check("hold_wht", out_data_wht, 8'h9C);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    cont = 1'b0;
    check("cont_busy", busy_raw, 1);
    check("cont_valid", out_valid_raw, 0);
    wait_valid(n);
    check("cont_latency", n, 9);
    @(posedge clock); #1;
    check("cont_end_busy", busy_raw, 0);

    // Mode change and start pulse during SHIFT are ignored
    push(8'h1C, 8'h9C);
    start_word(8'h01, MODE_FIB, 1'b0);
    mode = MODE_GAL; seed = 8'h80; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_valid(n);
    check("ignore_latency", n, 8);
    mode = MODE_FIB;
    @(posedge clock); #1;

    // Reset before the fourth shift abandons the word
    start_word(8'h01, MODE_FIB, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_valid", out_valid_raw, 0);
    check("mid_rst_busy", busy_raw, 0);
    check("mid_rst_raw", out_data_raw, 8'h00);
    check("mid_rst_wht", out_data_wht, 8'h63);
    reset = 1'b0;
    push(8'hB1, 8'hC8);
    start_word(8'h80, MODE_GAL, 1'b0);
    wait_valid(n);
    check("fresh_latency", n, 9);
    @(posedge clock); #1;
    check("fresh_drop_valid", out_valid_raw, 0);

    repeat (2) @(posedge clock); #1;
    check("raw_queue_empty", exp_raw_q.size(), 0);
    check("wht_queue_empty", exp_wht_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
